// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
// Optional early-out multiply is enabled by defining MULDIV_EARLY_OUT_EN.
package muldiv_pkg;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;

  localparam logic [XLEN_DEFAULT-1:0] MD_DIVZ_LO = '1;
endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage request/result bundle between the pipeline and the multiply/divide unit.
interface ex_muldiv_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);
  logic            Start_E;
  logic [1:0]      Op_E;
  logic [XLEN-1:0] SrcA_E;
  logic [XLEN-1:0] SrcB_E;
  logic            WrHi_E;
  logic            WrLo_E;
  logic [XLEN-1:0] WrData_E;
  logic            Busy_E;
  logic            Done_E;
  logic [XLEN-1:0] Hi_E;
  logic [XLEN-1:0] Lo_E;

  modport master (output Start_E, Op_E, SrcA_E, SrcB_E, WrHi_E, WrLo_E, WrData_E,
                  input  Busy_E, Done_E, Hi_E, Lo_E);
  modport slave  (input  Start_E, Op_E, SrcA_E, SrcB_E, WrHi_E, WrLo_E, WrData_E,
                  output Busy_E, Done_E, Hi_E, Lo_E);
endinterface

// File: rtl/ex_muldiv_step.sv
// One iteration of the MD datapath: shift-add multiply or restoring-divide step.
module muldiv_step import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rsh;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_rsh  = {i_hi, i_lo[XLEN-1]};
    w_diff = w_rsh - {1'b0, i_b};
    if (i_div) begin
      // Top bit of the difference is the borrow: clear means the divisor fits.
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_rsh[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MULDIV_EARLY_OUT_EN enables
// early termination of multiplies once the remaining multiplier bits are zero.
module ex_muldiv import muldiv_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN-1);
  localparam logic [XLEN-1:0]  DIVZ_LO = XLEN'(MD_DIVZ_LO);

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic sgn);
    return (sgn && v < 0) ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div, r_sneg, r_rneg, r_divz, r_done;
  logic [XLEN-1:0]  r_wh, r_wl, r_b, r_hi, r_lo;
  logic             w_div, w_signed, w_sa, w_sb, w_early;
  logic [XLEN-1:0]  w_mag_a, w_mag_b, w_hi, w_lo;
  logic [2*XLEN-1:0] w_next, w_prod;

  assign w_div    = (bus.Op_E == MD_DIV) || (bus.Op_E == MD_DIVU);
  assign w_signed = (bus.Op_E == MD_MULT) || (bus.Op_E == MD_DIV);
  assign w_sa     = w_signed & bus.SrcA_E[XLEN-1];
  assign w_sb     = w_signed & bus.SrcB_E[XLEN-1];
  assign w_mag_a  = mag(bus.SrcA_E, w_signed);
  assign w_mag_b  = mag(bus.SrcB_E, w_signed);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div (r_div),
    .i_hi  (r_wh),
    .i_lo  (r_wl),
    .i_b   (r_b),
    .o_hi  (w_hi),
    .o_lo  (w_lo)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]  r_mrem;
  logic [CNT_W-1:0] w_skip;
  // Skipped iterations would only shift the product right, so apply them at once.
  assign w_early = !r_div && (r_mrem[XLEN-1:1] == '0);
  assign w_skip  = LAST - r_cnt;
  assign w_next  = w_early ? ({w_hi, w_lo} >> w_skip) : {w_hi, w_lo};

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.Start_E) r_mrem <= w_mag_b;
    else if (r_state == ST_CALC)           r_mrem <= r_mrem >> 1;
  end
`else
  assign w_early = 1'b0;
  assign w_next  = {w_hi, w_lo};
`endif

  assign w_prod = r_sneg ? -{r_wh, r_wl} : {r_wh, r_wl};

  // Control, sign latches and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.Start_E) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
            r_div   <= w_div;
            r_sneg  <= w_sa ^ w_sb;
            r_rneg  <= w_sa;
            r_divz  <= (bus.SrcB_E == '0);
          end else begin
            if (bus.WrHi_E) r_hi <= bus.WrData_E;
            if (bus.WrLo_E) r_lo <= bus.WrData_E;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST || w_early) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_div) begin
            r_hi <= neg_x(r_wh, r_rneg);
            r_lo <= r_divz ? DIVZ_LO : neg_x(r_wl, r_sneg);
          end else begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Working datapath registers: {acc, multiplier} or {remainder, quotient}
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.Start_E) begin
      r_wh <= '0;
      r_wl <= w_div ? w_mag_a : w_mag_b;
      r_b  <= w_div ? w_mag_b : w_mag_a;
    end else if (r_state == ST_CALC) begin
      {r_wh, r_wl} <= w_next;
    end
  end

  assign bus.Busy_E = (r_state != ST_IDLE);
  assign bus.Done_E = r_done;
  assign bus.Hi_E   = r_hi;
  assign bus.Lo_E   = r_lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus randomized bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus();
  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // {HI, LO} expected from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mb;
    int n;
    if (op == MD_DIV || op == MD_DIVU) return 33;
    mb = (op == MD_MULT && b[31]) ? -b : b;
    n = 0;
    while (mb != 0) begin
      mb = mb >> 1;
      n++;
    end
    return (n < 1 ? 1 : n) + 1;
`else
    return 33 + 0 * int'(op) + 0 * int'(b[0]);
`endif
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic wrhi, input int inj);
    logic [63:0] r;
    int busy, ndone;
    r = ref_md(op, a, b);
    @(negedge clk);
    bus.Start_E = 1'b1; bus.Op_E = op; bus.SrcA_E = a; bus.SrcB_E = b;
    bus.WrHi_E = wrhi; bus.WrLo_E = wrhi; bus.WrData_E = 32'h0000_1234;
    @(negedge clk);
    bus.Start_E = 1'b0; bus.WrHi_E = 1'b0; bus.WrLo_E = 1'b0;
    busy = 0; ndone = 0;
    for (int i = 0; i < 100 && bus.Busy_E === 1'b1; i++) begin
      busy++;
      if (bus.Done_E !== 1'b0) ndone++;
      if (i == inj) begin
        bus.Start_E = 1'b1; bus.Op_E = MD_MULTU; bus.SrcA_E = 32'd2; bus.SrcB_E = 32'd2;
        bus.WrLo_E = 1'b1; bus.WrData_E = 32'h5555_5555;
      end else begin
        bus.Start_E = 1'b0; bus.WrLo_E = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start_E = 1'b0; bus.WrLo_E = 1'b0;
    chk($sformatf("%s.busy", tag), 32'(busy), 32'(exp_busy(op, b)));
    chk($sformatf("%s.done_in_busy", tag), 32'(ndone), 32'd0);
    chk($sformatf("%s.done", tag), {31'b0, bus.Done_E}, 32'd1);
    chk($sformatf("%s.hi", tag), bus.Hi_E, r[63:32]);
    chk($sformatf("%s.lo", tag), bus.Lo_E, r[31:0]);
    @(negedge clk);
    chk($sformatf("%s.done_clr", tag), {31'b0, bus.Done_E}, 32'd0);
  endtask

  initial begin
    int nd;
    logic [1:0] op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.Start_E = 1'b0; bus.Op_E = 2'b00; bus.SrcA_E = '0; bus.SrcB_E = '0;
    bus.WrHi_E = 1'b0; bus.WrLo_E = 1'b0; bus.WrData_E = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'b0, bus.Busy_E}, 32'd0);
    chk("rst.done", {31'b0, bus.Done_E}, 32'd0);
    chk("rst.hi", bus.Hi_E, 32'd0);
    chk("rst.lo", bus.Lo_E, 32'd0);
    rst = 1'b0;

    run_op("mult_neg3x7", MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, -1);
    chk("mult_neg3x7.hi_lit", bus.Hi_E, 32'hFFFFFFFF);
    chk("mult_neg3x7.lo_lit", bus.Lo_E, 32'hFFFFFFEB);
    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    chk("multu_max.hi_lit", bus.Hi_E, 32'hFFFFFFFE);
    run_op("div_neg7by2", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
    chk("div_neg7by2.lo_lit", bus.Lo_E, 32'hFFFFFFFD);
    run_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 1'b0, -1);
    chk("divu_by0.hi_lit", bus.Hi_E, 32'd100);
    run_op("div_by0_neg", MD_DIV, 32'hFFFFFF00, 32'd0, 1'b0, -1);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
    chk("div_ovf.lo_lit", bus.Lo_E, 32'h80000000);
    run_op("start_wins", MD_MULTU, 32'd3, 32'd4, 1'b1, -1);
    run_op("multu_5x1", MD_MULTU, 32'd5, 32'd1, 1'b0, -1);
    run_op("start_in_busy", MD_DIVU, 32'd1000, 32'd7, 1'b0, 5);

    @(negedge clk);
    bus.WrHi_E = 1'b1; bus.WrData_E = 32'h0000CAFE;
    @(negedge clk);
    bus.WrHi_E = 1'b0; bus.WrLo_E = 1'b1; bus.WrData_E = 32'h0000BEEF;
    chk("mthi", bus.Hi_E, 32'h0000CAFE);
    @(negedge clk);
    bus.WrLo_E = 1'b0;
    chk("mtlo", bus.Lo_E, 32'h0000BEEF);

    bus.Start_E = 1'b1; bus.Op_E = MD_DIVU; bus.SrcA_E = 32'hFFFF0000; bus.SrcB_E = 32'd3;
    @(negedge clk);
    bus.Start_E = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", {31'b0, bus.Busy_E}, 32'd0);
    chk("midrst.hi", bus.Hi_E, 32'd0);
    chk("midrst.lo", bus.Lo_E, 32'd0);
    chk("midrst.done", {31'b0, bus.Done_E}, 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done_E !== 1'b0 || bus.Busy_E !== 1'b0) nd++;
      @(negedge clk);
    end
    chk("midrst.quiet", 32'(nd), 32'd0);

    for (int k = 0; k < 16; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (k % 5 == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", k), op, a, b, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage iterative multiply/divide unit that consumes the EX-stage outputs of the ID/EX pipeline register.
- Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes and MFHI/MFLO reads.
- Raises Busy_E so the hazard unit can stall dependent MF*/MD ops (StallF/StallD, FlushE) while an operation is in flight.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- Start_E  in  1  launch an MD op this cycle; driven from decoded EX_E.
- Op_E  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- SrcA_E  in  XLEN  rs operand, already forwarded.
- SrcB_E  in  XLEN  rt operand, already forwarded.
- WrHi_E  in  1  MTHI write enable.
- WrLo_E  in  1  MTLO write enable.
- WrData_E  in  XLEN  MTHI/MTLO data.
- Busy_E  out  1  high while state is not IDLE.
- Done_E  out  1  one-cycle pulse when HI/LO take a new MD result.
- Hi_E  out  XLEN  HI register (MFHI source).
- Lo_E  out  XLEN  LO register (MFLO source).

Behaviour:
- Reset (rst=1 at posedge) has priority over everything: state=IDLE, counter=0, HI=LO=0, Busy_E=0, Done_E=0. Reset mid-operation abandons the op; no partial HI/LO update.
- States:
  - IDLE: on Start_E, latch Op_E, |SrcA|, |SrcB| (magnitudes for signed ops, raw for unsigned) and the result sign flags; counter=0; go to CALC.
  - CALC: one iteration per cycle. After the iteration with counter=XLEN-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, assert Done_E for the following cycle, go to IDLE.
- Multiply: shift-add on a 2*XLEN {acc, multiplier} register.
- Divide: restoring algorithm, one quotient bit per cycle.
- Latency: Start_E sampled at edge N, so Busy_E is high for cycles N+1..N+33 (32 CALC cycles + 1 FIX cycle). New HI/LO and Done_E are visible after edge N+33. Back-to-back Start_E is accepted in the first IDLE cycle after FIX.
- Start_E while Busy_E=1: ignored. The hazard unit must stall the op; this is a bench assertion.
- Signed sign rules:
  - MULT: product sign = sA^sB; negate the full 64-bit result in FIX.
  - DIV: quotient sign = sA^sB; remainder sign = sA.
- Results: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (SrcB=0): normal timing; HI=SrcA, LO=32'hFFFFFFFF for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of the magnitude algorithm; required).
- MTHI/MTLO: write the register at the edge, in IDLE only. Ignored while Busy_E=1.
- Start_E together with WrHi_E/WrLo_E in the same cycle: Start_E wins; the writes are dropped.
- Hi_E/Lo_E always show the architectural value. Intermediate results are never exposed.
- Done_E=0 except for the single cycle after FIX.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply ops leave CALC to FIX as soon as the remaining multiplier bits are all zero, with the product register pre-shifted by the skipped count. Minimum Busy_E is 2 cycles (one CALC + FIX), e.g. MULTU 5*1. Division is unaffected.
- Undefined: fixed 33-cycle Busy_E for all ops.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state typedef {IDLE, CALC, FIX};
  - XLEN_DEFAULT;
  - the divide-by-zero LO constant.
- One sub-module, muldiv_step: combinational single-iteration datapath (shift-add or restore-subtract step selected by op). ex_muldiv owns the FSM, counter, sign latches and HI/LO.

Test Plan:
- MULT SrcA=0xFFFFFFFD (-3), SrcB=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy_E high exactly 33 cycles; Done_E single pulse.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> HI=100, LO=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. Then MTHI 0x1234 in the same cycle as a new Start_E -> MTHI dropped, result written.
- rst asserted at cycle 10 of a DIVU -> next cycle Busy_E=0, HI=LO=0, no Done_E. Start_E during Busy_E is ignored and the original result is unchanged.
- With MULDIV_EARLY_OUT_EN: MULTU 5*1 -> Busy_E for 2 cycles, LO=5, HI=0. The same op without the macro -> 33 cycles.
